dt_stream_classifier: RTL and testbench
=======================================

// Module: dt_stream_classifier
// PURPOSE
//  Run-time programmable binary decision-tree classifier. Successor to the fixed, generated
//  combinational tree classifiers: the tree is held in a writable node table. It is walked one
//  node per clock. Samples arrive and results leave on valid/ready streams.
//  Sits between the feature-extraction front end and the class-vote/accumulate stage.
// PARAMETERS
//  N_FEAT     12  binary features per sample (width of in_feat)
//  CLASS_W    3   class label width
//  N_NODES    64  node-table entries; node 0 is the root
//  MAX_DEPTH  16  max internal nodes visited before abort
//  derived: FSEL_W=$clog2(N_FEAT), ADDR_W=$clog2(N_NODES), ENTRY_W=1+FSEL_W+2*ADDR_W
//  elaboration error if CLASS_W > FSEL_W+2*ADDR_W
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  rst_n      in   1        synchronous active-low reset
//  cfg_we     in   1        node-table write strobe
//  cfg_addr   in   ADDR_W   node index to write
//  cfg_wdata  in   ENTRY_W  node entry (format below)
//  cfg_ready  out  1        table writable this cycle (state==IDLE)
//  in_valid   in   1        sample valid
//  in_ready   out  1        sample accepted when in_valid&&in_ready
//  in_feat    in   N_FEAT   feature vector
//  out_valid  out  1        result valid
//  out_ready  in   1        result consumed when out_valid&&out_ready
//  out_class  out  CLASS_W  class label
//  out_err    out  1        depth-limit abort flag
// BEHAVIOUR
//  Entry: [ENTRY_W-1]=is_node; [ENTRY_W-2 -: FSEL_W]=feat sel; next [2*ADDR_W-1:ADDR_W]=child_t,
//   [ADDR_W-1:0]=child_f. Leaf (is_node=0): class = entry[CLASS_W-1:0], other bits ignored.
//  Reset (rst_n=0 at edge): state=IDLE; out_valid=0, out_class=0, out_err=0; all table entries=0
//   (every node = leaf class 0); step counter and node pointer = 0.
//  FSM IDLE -> WALK -> DONE -> IDLE.
//   IDLE: in_ready = !cfg_we. cfg_we has priority over in_valid in the same cycle: write
//    performed, sample not accepted. On accept: latch in_feat, ptr=0, steps=0, go WALK.
//   WALK: examine node[ptr] (one node per cycle, registered ptr).
//    leaf: out_class=class, out_err=0, go DONE.
//    internal, steps==MAX_DEPTH: out_class=0, out_err=1, go DONE.
//    internal otherwise: ptr = feat[sel] ? child_t : child_f; steps++.
//    sel >= N_FEAT reads as 0; child index >= N_NODES is taken mod 2^ADDR_W, then
//    (if >= N_NODES) it reads as an all-zero leaf.
//   DONE: out_valid=1; out_class/out_err held stable until out_ready. On handshake, go IDLE.
//   out_valid is 0 in IDLE and WALK.
//  Latency: L internal nodes on path -> out_valid rises on the (L+1)th edge after accept.
//   Root-leaf: 1 cycle. Abort: MAX_DEPTH+1 cycles.
//  Throughput: one sample in flight; next accept no earlier than the cycle after the out handshake.
//  cfg_we outside IDLE is dropped silently (cfg_ready=0). Table state is unchanged.
//  Latched sample is immune to in_feat changes after accept.
//  Table write in IDLE takes effect for the next accepted sample.
//  Reset mid-walk or in DONE: next cycle IDLE, out_valid=0, table cleared.
//  No combinational path from in_valid/out_ready to outputs. in_ready depends only on state and cfg_we.
// TESTING
//  T1 reset, no config, in_feat=12'hFFF -> out_class=0, out_err=0, out_valid 1 cycle after accept
//  T2 load n0={1,feat10,t=2,f=1}, n1=leaf 3'b110, n2=leaf 3'b001; in_feat[10]=1 -> 3'b001,
//     in_feat=0 -> 3'b110, both 2 cycles after accept
//  T3 n0={1,feat0,t=0,f=0} (self-loop) -> out_err=1, out_class=0, 17 cycles after accept
//  T4 T2 tree, out_ready=0 for 5 cycles -> out_valid/out_class stable, in_ready=0;
//     next sample accepted the cycle after out_ready=1
//  T5 cfg_we to n1=leaf 3'b011 during WALK -> cfg_ready=0; rerun T2 inp=0 -> still 3'b110;
//     same write in IDLE -> 3'b011
//  T6 rst_n=0 in WALK of 3-level tree -> out_valid=0 next cycle; fresh sample gives class 0

Source files
------------

// File: rtl/dt_stream_classifier.sv
// Programmable binary decision-tree classifier: node table walked one node per clock,
// with samples and results carried on valid/ready streams.
module dt_stream_classifier #(
   parameter int unsigned N_FEAT    = 12,
   parameter int unsigned CLASS_W   = 3,
   parameter int unsigned N_NODES   = 64,
   parameter int unsigned MAX_DEPTH = 16,
   localparam int unsigned FSEL_W   = $clog2(N_FEAT),
   localparam int unsigned ADDR_W   = $clog2(N_NODES),
   localparam int unsigned ENTRY_W  = 1 + FSEL_W + 2*ADDR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_we,
   input  logic [ADDR_W-1:0]  cfg_addr,
   input  logic [ENTRY_W-1:0] cfg_wdata,
   output logic               cfg_ready,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N_FEAT-1:0]  in_feat,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CLASS_W-1:0] out_class,
   output logic               out_err
);

   localparam int unsigned STEP_W = $clog2(MAX_DEPTH + 1);
   localparam int unsigned FPAD_W = 1 << FSEL_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WALK = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (CLASS_W > FSEL_W + 2*ADDR_W) begin : g_bad_class_w
      $error("CLASS_W does not fit in a node entry");
   end

   logic [1:0]         state_q, state_d;
   logic [ADDR_W-1:0]  ptr_q, ptr_d;
   logic [STEP_W-1:0]  steps_q, steps_d;
   logic [N_FEAT-1:0]  feat_q, feat_d;
   logic               ovalid_d, oerr_d;
   logic [CLASS_W-1:0] oclass_d;
   logic [ENTRY_W-1:0] tbl_q [N_NODES];

   logic [ENTRY_W-1:0] node;
   logic               node_is;
   logic [FSEL_W-1:0]  node_sel;
   logic [ADDR_W-1:0]  child_t, child_f;
   logic [FPAD_W-1:0]  feat_pad;
   logic               feat_bit;

   assign cfg_ready = (state_q == S_IDLE);
   assign in_ready  = (state_q == S_IDLE) && !cfg_we;

   // Pointers past the populated table decode as an all-zero leaf.
   always_comb begin : p_node_read
      node = '0;
      for (int i = 0; i < N_NODES; i++) begin
         if (ptr_q == ADDR_W'(i)) node = tbl_q[i];
      end
   end

   assign node_is  = node[ENTRY_W-1];
   assign node_sel = node[ENTRY_W-2 -: FSEL_W];
   assign child_t  = node[2*ADDR_W-1:ADDR_W];
   assign child_f  = node[ADDR_W-1:0];
   assign feat_pad = FPAD_W'(feat_q);
   assign feat_bit = feat_pad[node_sel];

   always_comb begin : p_next
      state_d  = state_q;
      ptr_d    = ptr_q;
      steps_d  = steps_q;
      feat_d   = feat_q;
      ovalid_d = out_valid;
      oclass_d = out_class;
      oerr_d   = out_err;
      case (state_q)
         S_IDLE: begin
            if (in_valid && !cfg_we) begin
               feat_d  = in_feat;
               ptr_d   = '0;
               steps_d = '0;
               state_d = S_WALK;
            end
         end
         S_WALK: begin
            if (!node_is) begin
               oclass_d = node[CLASS_W-1:0];
               oerr_d   = 1'b0;
               ovalid_d = 1'b1;
               state_d  = S_DONE;
            end else if (steps_q == STEP_W'(MAX_DEPTH)) begin
               oclass_d = '0;
               oerr_d   = 1'b1;
               ovalid_d = 1'b1;
               state_d  = S_DONE;
            end else begin
               ptr_d   = feat_bit ? child_t : child_f;
               steps_d = steps_q + STEP_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               ovalid_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: begin
            ovalid_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin : p_regs
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         steps_q   <= '0;
         feat_q    <= '0;
         out_valid <= 1'b0;
         out_class <= '0;
         out_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         steps_q   <= steps_d;
         feat_q    <= feat_d;
         out_valid <= ovalid_d;
         out_class <= oclass_d;
         out_err   <= oerr_d;
      end
   end

   // Node table: writable only while idle, cleared to class-0 leaves on reset.
   always_ff @(posedge clk) begin : p_table
      if (!rst_n) begin
         for (int i = 0; i < N_NODES; i++) tbl_q[i] <= '0;
      end else if (cfg_we && (state_q == S_IDLE)) begin
         tbl_q[cfg_addr] <= cfg_wdata;
      end
   end

endmodule

// File: tb/tb_dt_stream_classifier.sv
// Bench for dt_stream_classifier: directed scenarios plus random trees and samples,
// scored against a queue of results predicted by a behavioural tree walker.
module tb_dt_stream_classifier;

   localparam int N_FEAT  = 12;
   localparam int CLASS_W = 3;
   localparam int N_NODES = 64;
   localparam int ADDR_W  = 6;
   localparam int ENTRY_W = 17;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cfg_we;
   logic [ADDR_W-1:0]  cfg_addr;
   logic [ENTRY_W-1:0] cfg_wdata;
   logic               cfg_ready;
   logic               in_valid;
   logic               in_ready;
   logic [N_FEAT-1:0]  in_feat;
   logic               out_valid;
   logic               out_ready;
   logic [CLASS_W-1:0] out_class;
   logic               out_err;

   dt_stream_classifier dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
      .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
      .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cls;
      int err;
      int lat;
      int acc;
   } exp_t;

   exp_t               sb[$];
   logic [ENTRY_W-1:0] mtab [N_NODES];
   int                 tests = 0;
   int                 fails = 0;
   int                 cyc = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Walk the model table from the root following the tree rules directly.
   task automatic ref_walk(input logic [N_FEAT-1:0] f, output int cls, output int err,
                           output int lat);
      int n;
      int visited;
      logic [ENTRY_W-1:0] e;
      int sel;
      n = 0;
      visited = 0;
      forever begin
         e = (n < N_NODES) ? mtab[n] : '0;
         if (e[ENTRY_W-1] == 1'b0) begin
            cls = int'(e) % 8;
            err = 0;
            lat = visited + 1;
            return;
         end
         if (visited == 16) begin
            cls = 0;
            err = 1;
            lat = 17;
            return;
         end
         sel = (int'(e) >> 12) % 16;
         if (sel < N_FEAT && f[sel]) n = (int'(e) >> 6) % 64;
         else                        n = int'(e) % 64;
         visited++;
      end
   endtask

   // Monitor: observes mid-cycle what the next rising edge will commit.
   logic     held_valid = 1'b0;
   int       held_cls, held_err;
   always @(negedge clk) begin
      exp_t x;
      int   c, e, l;
      if (rst_n !== 1'b1) begin
         sb.delete();
         for (int i = 0; i < N_NODES; i++) mtab[i] = '0;
         held_valid = 1'b0;
      end else begin
         if (cfg_we && cfg_ready) mtab[cfg_addr] = cfg_wdata;
         if (out_valid) begin
            if (!held_valid) begin
               chk("result_expected", int'(sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  x = sb.pop_front();
                  chk("out_class", int'(out_class), x.cls);
                  chk("out_err", int'(out_err), x.err);
                  chk("latency", cyc - x.acc, x.lat);
               end
               held_cls = int'(out_class);
               held_err = int'(out_err);
            end else begin
               chk("hold_class", int'(out_class), held_cls);
               chk("hold_err", int'(out_err), held_err);
            end
            chk("in_ready_busy", int'(in_ready), 0);
         end
         held_valid = out_valid && !out_ready;
         if (in_valid && in_ready) begin
            ref_walk(in_feat, c, e, l);
            x.cls = c; x.err = e; x.lat = l; x.acc = cyc + 1;
            sb.push_back(x);
         end
      end
   end

   function automatic logic [ENTRY_W-1:0] mk_node(input int sel, input int t, input int f);
      return {1'b1, 4'(sel), 6'(t), 6'(f)};
   endfunction

   function automatic logic [ENTRY_W-1:0] mk_leaf(input int c);
      return {1'b0, 13'($urandom), 3'(c)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int addr, input logic [ENTRY_W-1:0] data);
      cfg_we = 1'b1;
      cfg_addr = ADDR_W'(addr);
      cfg_wdata = data;
      step();
      cfg_we = 1'b0;
      cfg_wdata = ENTRY_W'($urandom);
   endtask

   task automatic send(input logic [N_FEAT-1:0] f);
      bit acc;
      acc = 1'b0;
      in_valid = 1'b1;
      in_feat = f;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         step();
      end
      in_valid = 1'b0;
      in_feat = N_FEAT'($urandom);
      chk("accept", int'(acc), 1);
   endtask

   task automatic drain(input int hold);
      bit done;
      done = 1'b0;
      out_ready = 1'b0;
      repeat (hold) step();
      out_ready = 1'b1;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         done = out_valid;
         step();
      end
      out_ready = 1'b0;
      chk("result_handshake", int'(done), 1);
   endtask

   task automatic check_reset_outputs();
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_class", int'(out_class), 0);
      chk("rst_out_err", int'(out_err), 0);
      chk("rst_cfg_ready", int'(cfg_ready), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst_n = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
      repeat (3) step();
      check_reset_outputs();
      rst_n = 1'b1;
      chk("idle_in_ready", int'(in_ready), 1);

      // Empty table: every sample is class 0 from a root leaf.
      send(12'hFFF);
      drain(0);

      // Two-leaf tree on feature 10.
      wr(0, mk_node(10, 2, 1));
      wr(1, mk_leaf(6));
      wr(2, mk_leaf(1));
      send(12'h400 | N_FEAT'($urandom));
      drain(0);
      send(12'hBFF & N_FEAT'($urandom));
      drain(2);

      // Backpressure: result must hold and a waiting sample must stall.
      send(12'h400);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         seen = out_valid;
      end
      chk("bp_valid_seen", int'(seen), 1);
      in_valid = 1'b1;
      in_feat = 12'h000;
      repeat (5) begin
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_in_ready", int'(in_ready), 0);
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp_out_valid_drop", int'(out_valid), 0);
      chk("bp_in_ready_back", int'(in_ready), 1);
      send(12'h000);
      drain(0);

      // Writes while busy are dropped; writes while idle take effect.
      send(12'h000);
      chk("walk_cfg_ready", int'(cfg_ready), 0);
      wr(1, mk_leaf(3));
      drain(0);
      send(12'h000);
      drain(0);
      wr(1, mk_leaf(3));
      send(12'h000);
      drain(1);

      // Self-loop at the root hits the depth limit.
      wr(0, mk_node(0, 0, 0));
      send(N_FEAT'($urandom));
      drain(1);

      // Reset in the middle of a three-level walk.
      wr(0, mk_node(0, 1, 1));
      wr(1, mk_node(1, 2, 2));
      wr(2, mk_leaf(5));
      send(N_FEAT'($urandom));
      rst_n = 1'b0;
      step();
      check_reset_outputs();
      rst_n = 1'b1;
      send(12'hFFF);
      drain(0);

      // Random trees, samples, dropped writes and backpressure.
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 6)) begin
               if ($urandom_range(0, 1) == 0)
                  wr($urandom_range(0, 15), mk_node($urandom_range(0, 15),
                     $urandom_range(0, 20), $urandom_range(0, 20)));
               else
                  wr($urandom_range(0, 20), mk_leaf($urandom_range(0, 7)));
            end
         end
         send(N_FEAT'($urandom));
         if ($urandom_range(0, 3) == 0)
            wr($urandom_range(0, 15), mk_leaf($urandom_range(0, 7)));
         drain($urandom_range(0, 3));
      end

      repeat (3) step();
      chk("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
